// File: rtl/fetch_unit.sv
// Decoupled instruction fetch front end: owns the fetch PC, requests words
// from i_cache over req/ready and buffers {pc, inst} pairs for decode.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     CW       = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_req,
    output logic [XLEN-1:0] o_addr,
    input  logic            i_ready,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic            o_misaligned,
    input  logic            i_take,
    output logic [CW-1:0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DROP,
        S_TRAP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] fpc_q;
    logic [XLEN-1:0] fpc_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic            mis_mem  [DEPTH];

    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   count_q;

    logic            full;
    logic            misal;
    logic            flush;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_inst;
    logic            push_mis;

    assign full  = (count_q == FULL);
    assign misal = (fpc_q[1:0] != 2'b00);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_RUN;
            fpc_q   <= PC_RESET;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        flush     = 1'b0;
        push      = 1'b0;
        push_inst = '0;
        push_mis  = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (i_redirect) begin
                    flush = 1'b1;
                    fpc_d = i_redirect_pc;
                end else if (misal) begin
                    if (!full) begin
                        push     = 1'b1;
                        push_mis = 1'b1;
                        state_d  = S_TRAP;
                    end
                end else if (!full) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect && i_ready) begin
                    flush   = 1'b1;
                    fpc_d   = i_redirect_pc;
                    state_d = S_RUN;
                end else if (i_redirect) begin
                    flush   = 1'b1;
                    fpc_d   = i_redirect_pc;
                    state_d = S_DROP;
                end else if (i_ready) begin
                    push      = 1'b1;
                    push_inst = i_data;
                    fpc_d     = fpc_q + XLEN'(4);
                    state_d   = S_RUN;
                end
            end
            // i_cache still owes a response for an address we no longer want
            S_DROP: begin
                if (i_redirect) begin
                    flush = 1'b1;
                    fpc_d = i_redirect_pc;
                end else if (i_ready) begin
                    state_d = S_RUN;
                end
            end
            S_TRAP: begin
                if (i_redirect) begin
                    flush   = 1'b1;
                    fpc_d   = i_redirect_pc;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        o_req = (state_q == S_WAIT) || (state_q == S_DROP);
    end

    assign o_addr = fpc_q;
    assign pop    = i_take && o_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst && push) begin
            pc_mem[wr_q]   <= fpc_q;
            inst_mem[wr_q] <= push_inst;
            mis_mem[wr_q]  <= push_mis;
        end
    end

    // Head fields read as zero while the queue is empty
    assign o_valid      = (count_q != '0);
    assign o_count      = count_q;
    assign o_pc         = o_valid ? pc_mem[rd_q] : '0;
    assign o_inst       = o_valid ? inst_mem[rd_q] : '0;
    assign o_misaligned = o_valid ? mis_mem[rd_q] : 1'b0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue. It generalises the single-cycle fetch path (PC register plus one i-cache lookup per instruction) into a decoupled stage. The block owns the fetch PC, issues word requests to i_cache through a req/ready handshake, and buffers {pc, inst} pairs for decode. It handles redirects from branch/jump/CSR logic (trap, xRET), including redirects while a request is outstanding, and flags misaligned fetch targets.

Parameters:
XLEN, 32, data/address width
PC_RESET, 32'h0000_0000, fetch PC after reset
DEPTH, 4, prefetch queue entries; power of 2, >= 2
CW, $clog2(DEPTH+1), width of o_count (derived; not overridden)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
o_req  out  1  fetch request to i_cache; held until i_ready
o_addr  out  XLEN  fetch address; stable while o_req=1
i_ready  in  1  i_cache response strobe; i_data valid this cycle
i_data  in  XLEN  fetched instruction word
i_redirect  in  1  flush queue and restart fetch at i_redirect_pc
i_redirect_pc  in  XLEN  new fetch PC
o_valid  out  1  queue head valid
o_inst  out  XLEN  head instruction (0 when o_misaligned=1)
o_pc  out  XLEN  head PC
o_misaligned  out  1  head is an instruction-address-misaligned marker
i_take  in  1  decode consumes head this cycle
o_count  out  CW  occupied queue entries

Behaviour:
- Reset (i_rst=0 at posedge): state RUN, fpc=PC_RESET, queue empty. Outputs: o_req=0, o_addr=PC_RESET, o_valid=0, o_count=0, o_misaligned=0, o_inst=0, o_pc=0.
- o_addr = fpc at all times. o_req = (state==WAIT || state==DROP).
- Queue: circular buffer with DEPTH entries {pc, inst, mis}, rd/wr pointers of log2(DEPTH) bits that wrap, registered storage. The head is driven combinationally from the registers. o_valid = (count!=0).
- Pop: i_take && o_valid. i_take with o_valid=0 is ignored.
- FSM, priority top-down in each state:
  - RUN:
    - i_redirect: flush, fpc<=i_redirect_pc, stay RUN.
    - fpc[1:0]!=0: push {fpc, 0, mis=1}, go TRAP. Push only if count<DEPTH; otherwise wait in RUN.
    - count<DEPTH: go WAIT.
  - WAIT:
    - i_redirect && i_ready: discard data, flush, fpc<=i_redirect_pc, go RUN.
    - i_redirect: flush, fpc<=i_redirect_pc, go DROP.
    - i_ready: push {fpc, i_data, 0}, fpc<=fpc+4 (mod 2^XLEN), go RUN.
  - DROP (response pending but discarded):
    - i_redirect: fpc<=i_redirect_pc (latest wins), flush, stay DROP.
    - i_ready: discard, go RUN.
    - o_addr in DROP shows the new fpc; i_cache has already latched the old address.
  - TRAP: no fetching. i_redirect: flush, fpc<=i_redirect_pc, go RUN.
- Redirect overrides push and pop in the same cycle; the queue ends empty.
- A push and a pop in the same cycle leave count unchanged.
- Overflow is impossible: WAIT is entered only with count<DEPTH, and count cannot rise while WAIT is pending.
- Latency: i_ready at cycle N gives o_valid=1 at N+1 (queue empty before). Back-to-back requests are separated by one RUN cycle, giving a peak rate of 1 instruction per 2 cycles when i_ready is combinational-hit.
- Reset mid-request: everything returns to reset values immediately. i_cache is reset by the same i_rst, so no stale response is expected.

Test Plan:
- Reset release, i_ready one cycle after each o_req, data 0x13, 0x93, 0x113 -> o_addr 0x0, 0x4, 0x8; queue outputs (pc, inst) = (0x0, 0x13), (0x4, 0x93), (0x8, 0x113) in order; o_valid rises the cycle after the first i_ready.
- i_take held 0, DEPTH=4 -> four pushes, o_count=4, o_req stays 0. Then one i_take -> o_count=3, a new request issues at 0x10, then o_count returns to 4.
- Redirect to 0x200 while in WAIT (i_ready late by 3 cycles) -> state DROP, the late i_data is not pushed, o_count=0. Next request has o_addr=0x200; first queued pc=0x200.
- Redirect to 0x202 -> one entry with o_pc=0x202, o_misaligned=1, o_inst=0, and no o_req. Then redirect to 0x300 -> fetch resumes at 0x300.
- Same cycle: i_ready push and i_take pop with o_count=2 -> o_count stays 2 and the head advances. Redirect plus i_take plus i_ready in the same cycle -> o_count=0, fpc=redirect pc.
- i_rst=0 asserted while o_req=1 with 3 entries queued -> next cycle o_req=0, o_count=0, o_addr=PC_RESET.
